// File: rtl/miner_job_scheduler_if.sv
// Job push and result record handshakes between the CSR/CCI-P side and the job scheduler.
// master = CSR/consumer side, slave = scheduler.
interface miner_job_scheduler_if #(
  parameter int TAG_W = 8
);
  logic             job_valid;
  logic             job_ready;
  logic [255:0]     job_data;
  logic [255:0]     job_middata;
  logic [TAG_W-1:0] job_tag;

  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       res_status;
  logic [31:0]      res_nonce;
  logic [31:0]      res_cycles;

  modport master (
    output job_valid, job_data, job_middata, job_tag, res_ready,
    input  job_ready, res_valid, res_tag, res_status, res_nonce, res_cycles
  );

  modport slave (
    input  job_valid, job_data, job_middata, job_tag, res_ready,
    output job_ready, res_valid, res_tag, res_status, res_nonce, res_cycles
  );
endinterface

// File: rtl/miner_job_scheduler.sv
// Queues hashing jobs, loads each into the fpgaminer core, sequences its reset,
// bounds each run by a cycle budget and emits one result record per job.
//
// state  | meaning
// IDLE   | core held in reset; pops the queue head when one is available
// LOAD   | core held in reset for RESET_HOLD cycles with the new job applied
// RUN    | core running; exits on golden nonce, abort or budget exhausted
// REPORT | result record offered until the consumer accepts it
module miner_job_scheduler #(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 8,
  parameter int RESET_HOLD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  miner_job_scheduler_if.slave     bus,
  input  logic [31:0]              cfg_timeout,
  input  logic                     abort,
  output logic                     miner_reset,
  output logic [255:0]             miner_data,
  output logic [255:0]             miner_middata,
  input  logic [31:0]              miner_golden_nonce,
  input  logic                     miner_golden_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [1:0] RS_FOUND     = 2'd0;
  localparam logic [1:0] RS_EXHAUSTED = 2'd1;
  localparam logic [1:0] RS_ABORTED   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_REPORT
  } state_t;

  state_t state, state_n;

  logic [255:0]     q_data    [DEPTH];
  logic [255:0]     q_middata [DEPTH];
  logic [TAG_W-1:0] q_tag     [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       timeout_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       run_cnt;
  logic [31:0]       cyc_inc;
  logic              golden_q;
  logic [31:0]       golden_nonce_q;

  logic       push, pop;
  logic       run_exit, load_abort;
  logic [1:0] exit_status;

  // Readiness is taken from the pre-pop count, so a full queue never bypasses.
  assign bus.job_ready = (count != CNT_W'(DEPTH));
  assign push          = bus.job_valid && bus.job_ready;
  assign queue_count   = count;
  assign cyc_inc       = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    pop           = 1'b0;
    run_exit      = 1'b0;
    load_abort    = 1'b0;
    exit_status   = RS_FOUND;
    miner_reset   = (state != S_RUN);
    busy          = (state != S_IDLE);
    bus.res_valid = (state == S_REPORT);
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          load_abort = 1'b1;
          state_n    = S_REPORT;
        end else if (hold_cnt == '0) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (golden_q) begin
          run_exit    = 1'b1;
          exit_status = RS_FOUND;
        end else if (abort) begin
          run_exit    = 1'b1;
          exit_status = RS_ABORTED;
        end else if ((timeout_q != 32'd0) && (cyc_inc == timeout_q)) begin
          run_exit    = 1'b1;
          exit_status = RS_EXHAUSTED;
        end
        if (run_exit) state_n = S_REPORT;
      end
      S_REPORT: begin
        if (bus.res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr]    <= bus.job_data;
      q_middata[wr_ptr] <= bus.job_middata;
      q_tag[wr_ptr]     <= bus.job_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      miner_data     <= '0;
      miner_middata  <= '0;
      tag_q          <= '0;
      timeout_q      <= '0;
      hold_cnt       <= '0;
      run_cnt        <= '0;
      golden_q       <= 1'b0;
      golden_nonce_q <= '0;
      bus.res_tag    <= '0;
      bus.res_status <= '0;
      bus.res_nonce  <= '0;
      bus.res_cycles <= '0;
    end else begin
      golden_q       <= miner_golden_valid;
      golden_nonce_q <= miner_golden_nonce;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        miner_data    <= q_data[rd_ptr];
        miner_middata <= q_middata[rd_ptr];
        tag_q         <= q_tag[rd_ptr];
        timeout_q     <= cfg_timeout;
        hold_cnt      <= HOLD_W'(RESET_HOLD - 1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (state == S_LOAD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;

      if (state == S_LOAD)     run_cnt <= '0;
      else if (state == S_RUN) run_cnt <= cyc_inc;

      if (load_abort) begin
        bus.res_tag    <= tag_q;
        bus.res_status <= RS_ABORTED;
        bus.res_nonce  <= '0;
        bus.res_cycles <= '0;
      end else if (run_exit) begin
        bus.res_tag    <= tag_q;
        bus.res_status <= exit_status;
        bus.res_nonce  <= (exit_status == RS_FOUND) ? golden_nonce_q : 32'd0;
        bus.res_cycles <= cyc_inc;
      end
    end
  end

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Scoreboard bench for miner_job_scheduler: expected records are queued at push
// time and compared whenever the result port completes a handshake.
module tb_miner_job_scheduler;

  localparam int DEPTH      = 4;
  localparam int TAG_W      = 8;
  localparam int RESET_HOLD = 2;

  typedef struct {
    logic [7:0]  tag;
    logic [1:0]  status;
    logic [31:0] nonce;
    logic [31:0] cycles;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   cfg_timeout;
  logic          abort;
  logic          miner_reset;
  logic [255:0]  miner_data;
  logic [255:0]  miner_middata;
  logic [31:0]   miner_golden_nonce;
  logic          miner_golden_valid;
  logic          busy;
  logic [2:0]    queue_count;

  miner_job_scheduler_if #(.TAG_W(TAG_W)) bus ();

  miner_job_scheduler #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .cfg_timeout        (cfg_timeout),
    .abort              (abort),
    .miner_reset        (miner_reset),
    .miner_data         (miner_data),
    .miner_middata      (miner_middata),
    .miner_golden_nonce (miner_golden_nonce),
    .miner_golden_valid (miner_golden_valid),
    .busy               (busy),
    .queue_count        (queue_count)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  exp_t         sb[$];
  exp_t         mon_e;
  logic [255:0] last_data, last_middata;
  int           last_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_add(input logic [7:0] tag, input logic [1:0] st,
                        input logic [31:0] nonce, input logic [31:0] cyc);
    exp_t e;
    e.tag = tag; e.status = st; e.nonce = nonce; e.cycles = cyc;
    sb.push_back(e);
  endtask

  // Called just after a clock edge; returns just after the edge that accepted the job.
  task automatic push_job(input logic [7:0] tag);
    logic acc;
    int   ok;
    for (int k = 0; k < 8; k++) begin
      last_data[k*32 +: 32]    = $urandom;
      last_middata[k*32 +: 32] = $urandom;
    end
    bus.job_valid   = 1'b1;
    bus.job_tag     = tag;
    bus.job_data    = last_data;
    bus.job_middata = last_middata;
    ok = 0;
    for (int i = 0; i < 500 && ok == 0; i++) begin
      @(negedge clk);
      acc      = bus.job_ready;
      last_cnt = int'(queue_count);
      @(posedge clk);
      #1;
      if (acc) ok = 1;
    end
    bus.job_valid = 1'b0;
    if (ok == 0) check_eq("push_timeout", 0, 1);
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (miner_reset && n < 100) begin
      tick(1);
      n++;
    end
    if (miner_reset) check_eq("run_timeout", 0, 1);
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      tick(1);
      n++;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        check_eq("res_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("res_tag",    bus.res_tag,    mon_e.tag);
        check_eq("res_status", bus.res_status, mon_e.status);
        check_eq("res_nonce",  bus.res_nonce,  mon_e.nonce);
        check_eq("res_cycles", bus.res_cycles, mon_e.cycles);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    reset              = 1'b1;
    cfg_timeout        = 32'd0;
    abort              = 1'b0;
    miner_golden_nonce = 32'd0;
    miner_golden_valid = 1'b0;
    bus.job_valid      = 1'b0;
    bus.job_data       = '0;
    bus.job_middata    = '0;
    bus.job_tag        = '0;
    bus.res_ready      = 1'b1;
    tick(3);
    check_eq("rst_miner_reset", miner_reset, 1);
    check_eq("rst_res_valid",   bus.res_valid, 0);
    check_eq("rst_busy",        busy, 0);
    check_eq("rst_job_ready",   bus.job_ready, 1);
    check_eq("rst_count",       queue_count, 0);
    check_eq("rst_data",        miner_data[63:0], 0);
    check_eq("rst_res_cycles",  bus.res_cycles, 0);
    reset = 1'b0;
    tick(2);

    // Golden nonce reported in RUN cycle 10 is seen through golden_q one cycle later.
    cfg_timeout = 32'd0;
    sb_add(8'h11, 2'd0, 32'h0000BEEF, 32'd11);
    push_job(8'h11);
    wait_run(n);
    check_eq("load_latency", n, RESET_HOLD + 1);
    check_eq("miner_data",    miner_data, last_data);
    check_eq("miner_middata", miner_middata, last_middata);
    tick(9);
    miner_golden_valid = 1'b1;
    miner_golden_nonce = 32'h0000BEEF;
    tick(1);
    miner_golden_valid = 1'b0;
    miner_golden_nonce = 32'h12345678;
    wait_drain();

    // Budget exhausted; core reset returns the cycle after the 100th RUN cycle.
    cfg_timeout        = 32'd100;
    miner_golden_nonce = 32'hDEAD0000;
    sb_add(8'h22, 2'd1, 32'd0, 32'd100);
    push_job(8'h22);
    wait_run(n);
    n = 0;
    while (!miner_reset && n < 200) begin
      tick(1);
      n++;
    end
    check_eq("run_len", n, 100);
    check_eq("exh_res_valid", bus.res_valid, 1);
    wait_drain();

    // Five jobs against a four-entry queue while the core is busy.
    cfg_timeout = 32'd20;
    sb_add(8'h30, 2'd1, 32'd0, 32'd20);
    push_job(8'h30);
    wait_run(n);
    for (int i = 1; i <= 4; i++) begin
      sb_add(8'(8'h30 + i), 2'd1, 32'd0, 32'd20);
      push_job(8'(8'h30 + i));
      check_eq("fill_count", queue_count, i);
    end
    check_eq("full_ready", bus.job_ready, 0);
    sb_add(8'h35, 2'd1, 32'd0, 32'd20);
    push_job(8'h35);
    check_eq("fifth_accept_count", last_cnt, 3);
    wait_drain();
    check_eq("empty_count", queue_count, 0);

    // FOUND wins over a same-cycle abort.
    cfg_timeout = 32'd0;
    sb_add(8'h41, 2'd0, 32'hCAFE0041, 32'd6);
    push_job(8'h41);
    wait_run(n);
    tick(4);
    miner_golden_valid = 1'b1;
    miner_golden_nonce = 32'hCAFE0041;
    tick(1);
    miner_golden_valid = 1'b0;
    miner_golden_nonce = 32'h0;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_drain();

    // Abort while the core is still held in reset.
    sb_add(8'h42, 2'd2, 32'd0, 32'd0);
    push_job(8'h42);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("abort_load_reset", miner_reset, 1);
    wait_drain();

    // Abort in IDLE has no effect on the next job.
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("idle_abort_busy", busy, 0);
    cfg_timeout = 32'd5;
    sb_add(8'h43, 2'd1, 32'd0, 32'd5);
    push_job(8'h43);
    wait_drain();

    // Backpressure on the result port.
    bus.res_ready = 1'b0;
    cfg_timeout   = 32'd3;
    sb_add(8'h51, 2'd1, 32'd0, 32'd3);
    push_job(8'h51);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      tick(1);
      n++;
    end
    check_eq("bp_res_valid", bus.res_valid, 1);
    for (int i = 1; i <= 4; i++) begin
      sb_add(8'(8'h51 + i), 2'd1, 32'd0, 32'd3);
      push_job(8'(8'h51 + i));
      check_eq("bp_count", queue_count, i);
    end
    check_eq("bp_full_ready", bus.job_ready, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_tag !== 8'h51 || bus.res_status !== 2'd1 ||
          bus.res_cycles !== 32'd3 || bus.res_nonce !== 32'd0 || miner_reset !== 1'b1 ||
          queue_count !== 3'd4)
        bad++;
      tick(1);
    end
    check_eq("bp_stable", bad, 0);
    bus.res_ready = 1'b1;
    wait_drain();

    // Reset mid-run discards the job, its result and the queued work.
    cfg_timeout = 32'd0;
    push_job(8'h61);
    wait_run(n);
    push_job(8'h62);
    push_job(8'h63);
    check_eq("pre_rst_count", queue_count, 2);
    tick(3);
    reset = 1'b1;
    tick(1);
    check_eq("mid_rst_miner_reset", miner_reset, 1);
    check_eq("mid_rst_count",       queue_count, 0);
    check_eq("mid_rst_res_valid",   bus.res_valid, 0);
    check_eq("mid_rst_busy",        busy, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.res_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick(1);
    end
    check_eq("post_rst_quiet", bad, 0);
    check_eq("post_rst_ready", bus.job_ready, 1);
    check_eq("sb_left", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
